// File: rtl/stream_beat_packer_pkg.sv
// Shared constants, output-word type and lane keep-mask helper for the beat packer.
// The optional early-close path is enabled with PACKER_FLUSH_EN.
package stream_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_RATIO_DEF = 4;
  localparam int PACK_RATIO_MAX = 16;

  typedef struct packed {
    logic [DATA_WIDTH_DEF*PACK_RATIO_DEF-1:0] data;
    logic [PACK_RATIO_DEF-1:0]                keep;
    logic                                     last;
  } out_word_t;

  // Lanes 0..cnt hold real beats.
  function automatic logic [PACK_RATIO_MAX-1:0] keep_mask(input int cnt);
    logic [PACK_RATIO_MAX-1:0] m;
    for (int i = 0; i < PACK_RATIO_MAX; i++) m[i] = (i <= cnt);
    return m;
  endfunction
endpackage

// File: rtl/stream_beat_packer_if.sv
// Narrow-beat input and wide-word output handshakes of the beat packer.
// in_last/out_keep/out_last exist only with PACKER_FLUSH_EN.
interface stream_beat_packer_if import stream_pkg::*; #(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int pack_ratio = PACK_RATIO_DEF
);
  logic                             in_valid;
  logic [data_width-1:0]            in_data;
  logic                             in_ready;
  logic                             out_valid;
  logic [data_width*pack_ratio-1:0] out_data;
  logic                             out_ready;
`ifdef PACKER_FLUSH_EN
  logic                             in_last;
  logic [pack_ratio-1:0]            out_keep;
  logic                             out_last;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef PACKER_FLUSH_EN
    output in_last,
    input  out_keep, out_last,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef PACKER_FLUSH_EN
    input  in_last,
    output out_keep, out_last,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_beat_packer_out_reg.sv
// Registered wide-word output stage with valid/ready drain; load_ok tells the
// packer a closing beat can be taken this cycle. PACKER_FLUSH_EN adds keep/last.
module pack_out_reg #(
  parameter int data_width = 8,
  parameter int pack_ratio = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [data_width*pack_ratio-1:0] data_in,
`ifdef PACKER_FLUSH_EN
  input  logic [pack_ratio-1:0]            keep_in,
  input  logic                             last_in,
  output logic [pack_ratio-1:0]            keep,
  output logic                             last,
`endif
  input  logic                             ready,
  output logic                             valid,
  output logic [data_width*pack_ratio-1:0] data,
  output logic                             load_ok
);
  assign load_ok = !valid || ready;

  // Load wins over drain; the packer only loads when load_ok, so a stalled word is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
`ifdef PACKER_FLUSH_EN
      keep  <= '0;
      last  <= 1'b0;
`endif
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
`ifdef PACKER_FLUSH_EN
      keep  <= keep_in;
      last  <= last_in;
`endif
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_beat_packer.sv
// Packs pack_ratio narrow beats into one wide word on a registered valid/ready output.
// PACKER_FLUSH_EN: in_last closes a word early, with out_keep/out_last describing it.
module stream_beat_packer import stream_pkg::*; #(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int pack_ratio = PACK_RATIO_DEF
) (
  input logic           clk,
  input logic           rst,
  stream_beat_packer_if.slave bus
);
  localparam int CW = $clog2(pack_ratio);

  logic [CW-1:0]                         cnt;
  logic [pack_ratio-2:0][data_width-1:0] acc;
  logic [pack_ratio-1:0][data_width-1:0] word;
  logic closing, accept, load_ok;

`ifdef PACKER_FLUSH_EN
  assign closing = (cnt == CW'(pack_ratio-1)) || bus.in_last;
`else
  assign closing = (cnt == CW'(pack_ratio-1));
`endif

  // Non-closing beats never touch the output register, so they flow during a stall.
  assign bus.in_ready = !rst && (load_ok || !closing);
  assign accept       = bus.in_valid && bus.in_ready;

  // Lanes above cnt are already zero in acc, so an early close leaves them clear.
  always_comb begin
    word = '0;
    for (int l = 0; l < pack_ratio-1; l++) word[l] = acc[l];
    for (int l = 0; l < pack_ratio; l++)
      if (cnt == CW'(l)) word[l] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      if (closing) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        for (int l = 0; l < pack_ratio-1; l++)
          if (cnt == CW'(l)) acc[l] <= bus.in_data;
        cnt <= cnt + CW'(1);
      end
    end
  end

  pack_out_reg #(.data_width(data_width), .pack_ratio(pack_ratio)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && closing),
    .data_in (word),
`ifdef PACKER_FLUSH_EN
    .keep_in (pack_ratio'(keep_mask(int'(cnt)))),
    .last_in (bus.in_last),
    .keep    (bus.out_keep),
    .last    (bus.out_last),
`endif
    .ready   (bus.out_ready),
    .valid   (bus.out_valid),
    .data    (bus.out_data),
    .load_ok (load_ok)
  );
endmodule

// File: tb/tb_stream_beat_packer.sv
// Directed and randomized checks of stream_beat_packer against a beat-queue model.
module tb_stream_beat_packer;
  import stream_pkg::*;
  localparam int DW = DATA_WIDTH_DEF;
  localparam int PR = PACK_RATIO_DEF;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_beat_packer_if #(.data_width(DW), .pack_ratio(PR)) bus ();
  stream_beat_packer #(.data_width(DW), .pack_ratio(PR)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0, ir_low = 0;
  logic [DW-1:0]    part_q[$];
  logic [DW*PR-1:0] got_q[$];
  logic             m_ov = 1'b0;
  out_word_t        m_w = '0;
  logic             closing, exp_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW*PR-1:0] gq(input int i);
    return (got_q.size() > i) ? got_q[i] : '1;
  endfunction

  // One clock: drive, check outputs mid-cycle against the model, then advance the model.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l, input logic rdy, input logic r);
    bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy; rst = r;
`ifdef PACKER_FLUSH_EN
    bus.in_last = l;
`endif
    @(negedge clk);
    closing = (part_q.size() == PR-1) || (FLUSH && l);
    exp_rdy = !r && (!m_ov || rdy || !closing);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_data", 64'(bus.out_data), 64'(m_w.data));
`ifdef PACKER_FLUSH_EN
    chk("out_keep", 64'(bus.out_keep), 64'(m_w.keep));
    chk("out_last", 64'(bus.out_last), 64'(m_w.last));
`endif
    if (bus.out_valid && rdy && !r) got_q.push_back(bus.out_data);
    if (!bus.in_ready) ir_low++;
    @(posedge clk);
    if (r) begin
      part_q.delete(); m_ov = 1'b0; m_w = '0;
    end else if (v && exp_rdy) begin
      part_q.push_back(d);
      if (closing) begin
        m_w.data = '0;
        foreach (part_q[i]) m_w.data |= (DW*PR)'(part_q[i]) << (DW*i);
        m_w.keep = PR'((1 << part_q.size()) - 1);
        m_w.last = FLUSH && l;
        m_ov = 1'b1;
        part_q.delete();
      end else if (m_ov && rdy) m_ov = 1'b0;
    end else if (m_ov && rdy) m_ov = 1'b0;
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; rst = 1'b1;
`ifdef PACKER_FLUSH_EN
    bus.in_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Basic pack
    got_q.delete();
    cyc(1, 8'h11, 0, 1, 0); cyc(1, 8'h22, 0, 1, 0); cyc(1, 8'h33, 0, 1, 0); cyc(1, 8'h44, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("basic_cnt", 64'(got_q.size()), 64'd1);
    chk("basic_w", 64'(gq(0)), 64'h44332211);

    // Throughput
    got_q.delete(); ir_low = 0;
    for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("thru_ir_low", 64'(ir_low), 64'd0);
    chk("thru_cnt", 64'(got_q.size()), 64'd4);
    chk("thru_w0", 64'(gq(0)), 64'h03020100);
    chk("thru_w1", 64'(gq(1)), 64'h07060504);
    chk("thru_w2", 64'(gq(2)), 64'h0B0A0908);
    chk("thru_w3", 64'(gq(3)), 64'h0F0E0D0C);

    // Backpressure
    got_q.delete(); ir_low = 0;
    for (int i = 1; i <= 7; i++) cyc(1, DW'(i), 0, 0, 0);
    chk("bp_ir_before", 64'(ir_low), 64'd0);
    cyc(1, 8'h08, 0, 0, 0); cyc(1, 8'h08, 0, 0, 0);
    chk("bp_ir_stall", 64'(ir_low), 64'd2);
    cyc(1, 8'h08, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("bp_cnt", 64'(got_q.size()), 64'd2);
    chk("bp_w0", 64'(gq(0)), 64'h04030201);
    chk("bp_w1", 64'(gq(1)), 64'h08070605);

    // Reset mid-word
    got_q.delete();
    cyc(1, 8'h11, 0, 1, 0); cyc(1, 8'h22, 0, 1, 0);
    cyc(0, '0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, DW'(8'h33 + i), 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("rst_cnt", 64'(got_q.size()), 64'd1);
    chk("rst_w", 64'(gq(0)), 64'h36353433);

`ifdef PACKER_FLUSH_EN
    // Partial flush
    got_q.delete();
    cyc(1, 8'hAA, 0, 1, 0); cyc(1, 8'hBB, 1, 1, 0);
    chk("fl_keep", 64'(bus.out_keep), 64'h3);
    chk("fl_last", 64'(bus.out_last), 64'h1);
    cyc(1, 8'hCC, 0, 1, 0); cyc(1, 8'hDD, 0, 1, 0); cyc(1, 8'hEE, 0, 1, 0); cyc(1, 8'hFF, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    chk("fl_w0", 64'(gq(0)), 64'h0000BBAA);
    chk("fl_w1", 64'(gq(1)), 64'hFFEEDDCC);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_beat_packer.md
# stream_beat_packer

- Downstream neighbour of the single-stage valid/ready register.
- Consumes its narrow `data_width`-bit beat stream and packs `pack_ratio` consecutive beats into one wide word.
- Presents each wide word on a registered valid/ready output.
- Sustains one input beat per cycle under continuous `out_ready`; backpressure propagates upstream through `in_ready`.

## Interface
- `data_width`, 8: width of one input beat in bits.
- `pack_ratio`, 4: beats per output word; legal range 2..16.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `in_valid`  input  1  upstream beat valid.
- `in_data`  input  `data_width`  upstream beat.
- `in_ready`  output  1  beat accepted when `in_valid && in_ready` at the `clk` edge.
- `in_last`  input  1  (only with `PACKER_FLUSH_EN`) beat closes the current word early.
- `out_valid`  output  1  wide word available.
- `out_data`  output  `data_width*pack_ratio`  packed word; beat 0 in LSBs.
- `out_ready`  input  1  downstream accepts when `out_valid && out_ready` at the `clk` edge.
- `out_keep`  output  `pack_ratio`  (only with `PACKER_FLUSH_EN`) one bit per lane, set when the lane holds a real beat.
- `out_last`  output  1  (only with `PACKER_FLUSH_EN`) word was closed by `in_last`.

## Operation
- **State**
  - `cnt`: lane index, `$clog2(pack_ratio)` bits.
  - Accumulator: `pack_ratio-1` lanes.
  - Output register: `out_data`/`out_valid` (plus `out_keep`/`out_last`).
- **Normal (non-closing) beat:** an accepted beat with `cnt < pack_ratio-1` is written to accumulator lane `cnt`; then `cnt` increments.
- **Closing beat:** an accepted beat with `cnt == pack_ratio-1`, or with `in_last` under the macro, closes the word.
  - Accumulator lanes plus the current beat (in lane `cnt`) load the output register in the same cycle.
  - `cnt` returns to 0 and all accumulator lanes clear to 0.
- **`in_ready`** = `!rst && (!out_valid || out_ready || !closing)`, where `closing` = (`cnt == pack_ratio-1`) or, under the macro, `in_last`. Non-closing beats are accepted even while the output is stalled.
- **Output register**
  - Loads when a closing beat is accepted.
  - Otherwise clears `out_valid` when `out_valid && out_ready`.
  - Load and drain in the same cycle: the load wins and `out_valid` stays 1.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `cnt` = 0, accumulator = 0.
  - `out_keep` = 0, `out_last` = 0.
  - `in_ready` = 0 while `rst` is high; 1 in the first cycle after release.
- **Reset mid-word or mid-stall:** the partial word and any pending output word are discarded with no output beat. Upstream must resend.

## Timing
- **Latency:** `out_valid` rises the cycle after the closing beat is accepted.
- **Throughput:** one word per `pack_ratio` cycles with continuous `in_valid` and `out_ready`, with no bubbles.
- `in_ready` is combinational from `cnt`, `out_valid`, `out_ready` (and `in_last`). There is no path from `in_valid` to `in_ready`.
- `out_valid`, `out_data`, `out_keep` and `out_last` are registered outputs.

## Configuration
- **With `PACKER_FLUSH_EN` defined:**
  - `in_last`, `out_keep` and `out_last` exist.
  - A last-flagged beat closes the word at any `cnt`.
  - `out_keep` = (`1 << (cnt+1)`) - 1.
  - Unfilled lanes are 0.
  - `out_last` = 1 for that word.
- **Without the macro:**
  - These ports are absent.
  - Words close only at `cnt == pack_ratio-1`.

## Structure
- **`stream_pkg`:**
  - Default `data_width` and `pack_ratio`.
  - `keep_mask(cnt)` function.
  - Typedef of the output word struct (data, keep, last).
- **Sub-module `pack_out_reg`:**
  - Holds the output word and its valid/ready drain logic.
  - Exports `load_ok` to the packer.

## Test plan
- **Basic pack:** reset, then 0x11, 0x22, 0x33, 0x44 back-to-back with `out_ready`=1 → `out_data`=0x44332211 and `out_valid`=1 exactly one cycle after the 0x44 acceptance.
- **Stream throughput:** 16 consecutive beats 0x00..0x0F with `out_ready`=1 → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, and `in_ready` never low.
- **Backpressure:**
  - Stimulus: `out_ready`=0, stream 0x01..0x08.
  - After the first word, `in_ready` drops only when beat 0x08 arrives at `cnt`=3.
  - Raise `out_ready` for one cycle → 0x04030201 drains and 0x08070605 loads in the same cycle.
- **Partial flush (macro on):** 0xAA, then 0xBB with `in_last`=1 → `out_data`=0x0000BBAA, `out_keep`=4'b0011, `out_last`=1; the next word starts at lane 0.
- **Reset mid-word:** accept 0x11, 0x22, assert `rst` one cycle, then send 0x33..0x36 → only 0x36353433 is output; `in_ready`=0 during reset.
